// File: rtl/fpa_addsub_seq.sv
// fpa_addsub_seq: multi-cycle floating-point add/subtract with a start/busy/done handshake.
// Word is {sign, biased exponent, fraction} with a hidden 1, flush-to-zero and truncating rounding.
module fpa_addsub_seq #(
   parameter int EXP_W = 3,
   parameter int MAN_W = 4
) (
   input  logic                 clk,
   input  logic                 clr,
   input  logic                 start,
   input  logic                 op,
   input  logic [EXP_W+MAN_W:0] a,
   input  logic [EXP_W+MAN_W:0] b,
   output logic [EXP_W+MAN_W:0] ans,
   output logic [3:0]           ans_except,
   output logic                 busy,
   output logic                 done,
   output logic [2:0]           state
);
   localparam int W     = 1 + EXP_W + MAN_W;
   localparam int MW    = MAN_W + 4;
   localparam int SHMAX = MAN_W + 3;
   localparam int CW    = $clog2(SHMAX + 1);
   localparam logic [EXP_W-1:0] EMAX = {EXP_W{1'b1}};
   localparam logic [EXP_W-1:0] EONE = EXP_W'(1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_ALIGN = 3'd2,
      S_ADD   = 3'd3,
      S_NORM  = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   state_t           r_state, w_next;
   logic [W-1:0]     r_a, r_b, r_ans;
   logic [3:0]       r_exc;
   logic             r_sl, r_ss;
   logic [EXP_W-1:0] r_el;
   logic [MW-1:0]    r_ml, r_ms;
   logic [CW-1:0]    r_cnt;

   logic [EXP_W-1:0] w_ea, w_eb, w_diff, w_el_inc, w_el_dec;
   logic [MAN_W-1:0] w_fa, w_fb;
   logic             w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero;
   logic             w_nan, w_special, w_a_ge, w_carry, w_hidden;
   logic [CW-1:0]    w_cnt0;
   logic [MW-1:0]    w_ma, w_mb, w_sum;

   assign w_ea      = r_a[W-2:MAN_W];
   assign w_eb      = r_b[W-2:MAN_W];
   assign w_fa      = r_a[MAN_W-1:0];
   assign w_fb      = r_b[MAN_W-1:0];
   assign w_a_nan   = (w_ea == EMAX) && (w_fa != '0);
   assign w_b_nan   = (w_eb == EMAX) && (w_fb != '0);
   assign w_a_inf   = (w_ea == EMAX) && (w_fa == '0);
   assign w_b_inf   = (w_eb == EMAX) && (w_fb == '0);
   assign w_a_zero  = (w_ea == '0);
   assign w_b_zero  = (w_eb == '0);
   // r_b already carries the effective sign, so Inf-Inf means opposite stored signs here
   assign w_nan     = w_a_nan || w_b_nan || (w_a_inf && w_b_inf && (r_a[W-1] != r_b[W-1]));
   assign w_special = w_nan || w_a_inf || w_b_inf || w_a_zero || w_b_zero;

   assign w_a_ge    = (r_a[W-2:0] >= r_b[W-2:0]);
   assign w_diff    = w_a_ge ? (w_ea - w_eb) : (w_eb - w_ea);
   assign w_cnt0    = (int'(w_diff) > SHMAX) ? CW'(SHMAX) : CW'(w_diff);
   assign w_ma      = {1'b0, 1'b1, w_fa, 2'b00};
   assign w_mb      = {1'b0, 1'b1, w_fb, 2'b00};
   assign w_sum     = (r_sl == r_ss) ? (r_ml + r_ms) : (r_ml - r_ms);
   assign w_carry   = r_ml[MW-1];
   assign w_hidden  = r_ml[MW-2];
   assign w_el_inc  = r_el + 1'b1;
   assign w_el_dec  = r_el - 1'b1;

   always_ff @(posedge clk or posedge clr) begin
      if (clr) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (start) w_next = S_LOAD;
         S_LOAD:  w_next = w_special ? S_DONE : S_ALIGN;
         S_ALIGN: if (r_cnt == '0) w_next = S_ADD;
         S_ADD:   w_next = (w_sum == '0) ? S_DONE : S_NORM;
         S_NORM:  if (w_carry || w_hidden || (r_el == EONE)) w_next = S_DONE;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      case (r_state)
         S_IDLE: if (start) begin
            r_a <= a;
            r_b <= {b[W-1] ^ op, b[W-2:0]};
         end
         S_LOAD: begin
            r_cnt <= w_cnt0;
            if (w_a_ge) begin
               r_sl <= r_a[W-1]; r_el <= w_ea; r_ml <= w_ma;
               r_ss <= r_b[W-1]; r_ms <= w_mb;
            end else begin
               r_sl <= r_b[W-1]; r_el <= w_eb; r_ml <= w_mb;
               r_ss <= r_a[W-1]; r_ms <= w_ma;
            end
         end
         S_ALIGN: if (r_cnt != '0) begin
            r_ms  <= r_ms >> 1;
            r_cnt <= r_cnt - 1'b1;
         end
         S_ADD: r_ml <= w_sum;
         S_NORM: begin
            if (w_carry) begin
               r_ml <= r_ml >> 1;
               r_el <= w_el_inc;
            end else if (!w_hidden) begin
               r_ml <= r_ml << 1;
               r_el <= w_el_dec;
            end
         end
         default: ;
      endcase
   end

   // Result and flags are written only on the cycle that decides them, then held
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         r_ans <= '0;
         r_exc <= '0;
      end else begin
         case (r_state)
            S_IDLE: if (start) r_exc <= '0;
            S_LOAD: begin
               if (w_nan) begin
                  r_ans <= {1'b0, EMAX, 1'b1, {(MAN_W-1){1'b0}}};
                  r_exc <= 4'b1000;
               end else if (w_a_inf) r_ans <= r_a;
               else if (w_b_inf) r_ans <= r_b;
               else if (w_a_zero && w_b_zero) begin
                  r_ans <= '0;
                  r_exc <= 4'b0001;
               end else if (w_a_zero) r_ans <= r_b;
               else if (w_b_zero) r_ans <= r_a;
            end
            S_ADD: if (w_sum == '0) begin
               r_ans <= '0;
               r_exc <= 4'b0001;
            end
            S_NORM: begin
               if (w_carry) begin
                  if (w_el_inc == EMAX) begin
                     r_ans <= {r_sl, EMAX, {MAN_W{1'b0}}};
                     r_exc <= 4'b0100;
                  end else r_ans <= {r_sl, w_el_inc, r_ml[MAN_W+2:3]};
               end else if (w_hidden) r_ans <= {r_sl, r_el, r_ml[MAN_W+1:2]};
               else if (r_el == EONE) begin
                  r_ans <= '0;
                  r_exc <= 4'b0011;
               end
            end
            default: ;
         endcase
      end
   end

   assign ans        = r_ans;
   assign ans_except = r_exc;
   assign busy       = (r_state != S_IDLE);
   assign done       = (r_state == S_DONE);
   assign state      = r_state;

endmodule

// File: tb/tb_fpa_addsub_seq.sv
// Directed bench for fpa_addsub_seq (EXP_W=3, MAN_W=4) against a value-level reference model.
module tb_fpa_addsub_seq;
   localparam int EXP_W = 3;
   localparam int MAN_W = 4;
   localparam int W     = 1 + EXP_W + MAN_W;

   logic         clk = 1'b0;
   logic         clr, start, op;
   logic [W-1:0] a, b, ans;
   logic [3:0]   ans_except;
   logic         busy, done;
   logic [2:0]   state;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   fpa_addsub_seq #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
      .clk(clk), .clr(clr), .start(start), .op(op), .a(a), .b(b),
      .ans(ans), .ans_except(ans_except), .busy(busy), .done(done), .state(state)
   );

   typedef struct { int ans; int exc; int lat; } res_t;

   task automatic check(input string name, input int got, input int want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s got=%0h want=%0h", name, got, want);
      end
   endtask

   // Reference: exact integer arithmetic on scaled significands, truncated alignment, then normalisation
   function automatic res_t model(input int x, input int y, input int opb);
      res_t r;
      int emax, mask, sx, sy, ex, ey, fx, fy, ybits, sl, el, ml, ms, d, rr, k;
      bit xn, yn, xi, yi, xz, yz;
      emax  = (1 << EXP_W) - 1;
      mask  = (1 << MAN_W) - 1;
      sx    = (x >> (W-1)) & 1;
      sy    = ((y >> (W-1)) & 1) ^ (opb & 1);
      ex    = (x >> MAN_W) & emax;
      ey    = (y >> MAN_W) & emax;
      fx    = x & mask;
      fy    = y & mask;
      ybits = (sy << (W-1)) | (y & ((1 << (W-1)) - 1));
      xn = (ex == emax) && (fx != 0);
      yn = (ey == emax) && (fy != 0);
      xi = (ex == emax) && (fx == 0);
      yi = (ey == emax) && (fy == 0);
      xz = (ex == 0);
      yz = (ey == 0);
      r.exc = 0;
      r.lat = 1;
      if (xn || yn || (xi && yi && (sx != sy))) begin
         r.ans = (emax << MAN_W) | (1 << (MAN_W-1));
         r.exc = 8;
         return r;
      end
      if (xi)       begin r.ans = x;     return r; end
      if (yi)       begin r.ans = ybits; return r; end
      if (xz && yz) begin r.ans = 0; r.exc = 1; return r; end
      if (xz)       begin r.ans = ybits; return r; end
      if (yz)       begin r.ans = x;     return r; end
      if ((ex << MAN_W) + fx >= (ey << MAN_W) + fy) begin
         sl = sx; el = ex; ml = ((1 << MAN_W) + fx) * 4; ms = ((1 << MAN_W) + fy) * 4; d = ex - ey;
      end else begin
         sl = sy; el = ey; ml = ((1 << MAN_W) + fy) * 4; ms = ((1 << MAN_W) + fx) * 4; d = ey - ex;
      end
      if (d > MAN_W + 3) d = MAN_W + 3;
      rr = (sx == sy) ? ml + (ms >> d) : ml - (ms >> d);
      if (rr == 0) begin
         r.ans = 0; r.exc = 1; r.lat = 3 + d;
         return r;
      end
      if (rr >= (1 << (MAN_W+3))) begin
         rr = rr >> 1;
         el = el + 1;
         r.lat = 4 + d;
         if (el == emax) begin
            r.ans = (sl << (W-1)) | (emax << MAN_W);
            r.exc = 4;
         end else r.ans = (sl << (W-1)) | (el << MAN_W) | ((rr >> 2) & mask);
         return r;
      end
      k = 0;
      while (rr < (1 << (MAN_W+2))) begin
         rr = rr << 1;
         el = el - 1;
         k++;
         if (el == 0) break;
      end
      if (el == 0) begin
         r.ans = 0; r.exc = 3; r.lat = 3 + d + k;
      end else begin
         r.ans = (sl << (W-1)) | (el << MAN_W) | ((rr >> 2) & mask);
         r.lat = 4 + d + k;
      end
      return r;
   endfunction

   task automatic run(input string name, input int x, input int y, input int o,
                      input int want_ans, input int want_exc, input int ign_cyc);
      res_t m;
      int   cyc;
      bit   seen, busy_bad;
      m = model(x, y, o);
      check({name, " model_ans"}, m.ans, want_ans);
      check({name, " model_exc"}, m.exc, want_exc);
      @(negedge clk);
      a = W'(x); b = W'(y); op = o[0]; start = 1'b1;
      @(negedge clk);
      start = 1'b0; a = '0; b = '0; op = 1'b0;
      cyc = 0; seen = 1'b0; busy_bad = 1'b0;
      while (!seen && cyc < 60) begin
         @(posedge clk); #1;
         cyc++;
         if (start) begin
            start = 1'b0; a = '0; b = '0; op = 1'b0;
         end
         if (done) seen = 1'b1;
         else begin
            if (!busy) busy_bad = 1'b1;
            if (cyc == ign_cyc) begin
               a = 8'h11; b = 8'h22; op = 1'b1; start = 1'b1;
            end
         end
      end
      check({name, " done_seen"}, int'(seen), 1);
      check({name, " latency"}, cyc, m.lat);
      check({name, " ans"}, int'(ans), m.ans);
      check({name, " except"}, int'(ans_except), m.exc);
      check({name, " busy_low"}, int'(busy_bad), 0);
      @(posedge clk); #1;
      check({name, " done_pulse"}, int'(done), 0);
      check({name, " idle_busy"}, int'(busy), 0);
      check({name, " ans_hold"}, int'(ans), m.ans);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1);
   end

   initial begin
      res_t m;
      clr = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
      #2;
      check("reset ans", int'(ans), 0);
      check("reset except", int'(ans_except), 0);
      check("reset busy", int'(busy), 0);
      check("reset done", int'(done), 0);
      @(negedge clk);
      @(negedge clk);
      clr = 1'b0;

      m = model('h3D, 'h34, 0);
      check("pin 3D+34 latency", m.lat, 4);
      m = model('h48, 'h3F, 1);
      check("pin 48-3F latency", m.lat, 6);

      run("3D+34", 'h3D, 'h34, 0, 'h48, 0, 0);
      run("60+10", 'h60, 'h10, 0, 'h60, 0, 2);
      run("48-3F", 'h48, 'h3F, 1, 'h31, 0, 0);
      run("3D-3D", 'h3D, 'h3D, 1, 'h00, 1, 0);
      run("6F+6F", 'h6F, 'h6F, 0, 'h70, 4, 0);
      run("13-12", 'h13, 'h12, 1, 'h00, 3, 0);
      run("78+30", 'h78, 'h30, 0, 'h78, 8, 0);
      run("00-34", 'h00, 'h34, 1, 'hB4, 0, 0);
      run("80+00", 'h80, 'h00, 0, 'h00, 1, 0);
      run("70-70", 'h70, 'h70, 1, 'h78, 8, 0);
      run("70+C0", 'h70, 'hC0, 0, 'h70, 0, 0);
      run("34-3D", 'h34, 'h3D, 1, 'hA2, 0, 0);
      run("BD+34", 'hBD, 'h34, 0, 'hA2, 0, 0);

      // Abort an operation while it is normalising, then confirm a clean restart
      @(negedge clk);
      a = 8'h5F; b = 8'h5E; op = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0; a = '0; b = '0; op = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      check("pre-clr busy", int'(busy), 1);
      clr = 1'b1;
      #1;
      check("clr ans", int'(ans), 0);
      check("clr except", int'(ans_except), 0);
      check("clr busy", int'(busy), 0);
      check("clr done", int'(done), 0);
      @(negedge clk);
      clr = 1'b0;
      run("5F-5E post-clr", 'h5F, 'h5E, 1, 'h10, 0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
